// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: two-requester command scheduler for the LCD image controller.
// Each requester feeds a small command FIFO; a round-robin arbiter hands one
// command at a time to the controller, then waits for the controller to go
// busy and idle again before issuing the next one.
module lcd_cmd_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req0_cmd,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req1_cmd,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic       grant_id,
    output logic [7:0] issue_cnt,
    output logic       err,
    output logic       finished
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [3:0] FIRST_ILLEGAL = 4'd12;

    typedef enum logic [2:0] {
        WAIT_RDY,
        ISSUE,
        WAIT_BUSY,
        WAIT_IDLE,
        FINISHED
    } state_t;

    state_t state, state_n;

    logic [3:0]  mem0 [FIFO_DEPTH];
    logic [3:0]  mem1 [FIFO_DEPTH];
    logic [AW:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic        empty0, full0, empty1, full1;
    logic        hs0, hs1, push0, push1, bad0, bad1;
    logic        issue, sel, timeout, prio;
    logic [1:0]  timer, timer_n;
    logic [3:0]  pop_cmd;

    // The extra pointer bit separates "full" (same slot, different lap) from "empty".
    assign empty0 = (wr_ptr0 == rd_ptr0);
    assign full0  = (wr_ptr0[AW] != rd_ptr0[AW]) && (wr_ptr0[AW-1:0] == rd_ptr0[AW-1:0]);
    assign empty1 = (wr_ptr1 == rd_ptr1);
    assign full1  = (wr_ptr1[AW] != rd_ptr1[AW]) && (wr_ptr1[AW-1:0] == rd_ptr1[AW-1:0]);

    // Ready looks only at pre-edge occupancy, so a pop on a full FIFO does not
    // let a same-edge enqueue in.
    assign req0_ready = !full0 && !finished;
    assign req1_ready = !full1 && !finished;

    // Codes 12..15 complete the handshake but are dropped and flagged.
    assign hs0   = req0_valid && req0_ready;
    assign hs1   = req1_valid && req1_ready;
    assign push0 = hs0 && (req0_cmd < FIRST_ILLEGAL);
    assign push1 = hs1 && (req1_cmd < FIRST_ILLEGAL);
    assign bad0  = hs0 && (req0_cmd >= FIRST_ILLEGAL);
    assign bad1  = hs1 && (req1_cmd >= FIRST_ILLEGAL);

    // prio names the requester favoured when both have work; otherwise take
    // whichever FIFO is occupied.
    assign sel     = (!empty0 && !empty1) ? prio : empty0;
    assign pop_cmd = sel ? mem1[rd_ptr1[AW-1:0]] : mem0[rd_ptr0[AW-1:0]];

    // Next-state logic: issue, strobe, wait for busy (with timeout), wait for idle.
    always_comb begin
        state_n = state;
        timer_n = timer;
        issue   = 1'b0;
        timeout = 1'b0;
        if (lcd_done) begin
            state_n = FINISHED;
        end else begin
            case (state)
                WAIT_RDY: begin
                    if (!lcd_busy && (!empty0 || !empty1)) begin
                        issue   = 1'b1;
                        state_n = ISSUE;
                    end
                end
                ISSUE: begin
                    timer_n = 2'd0;
                    state_n = WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (lcd_busy) begin
                        state_n = WAIT_IDLE;
                    end else begin
                        timer_n = timer + 2'd1;
                        if (timer == 2'd2) begin
                            timeout = 1'b1;
                            state_n = WAIT_RDY;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A write keeps the controller busy for 64+ cycles, so no timeout here.
                    if (!lcd_busy) begin
                        state_n = WAIT_RDY;
                    end
                end
                FINISHED: begin
                    state_n = FINISHED;
                end
                default: begin
                    state_n = WAIT_RDY;
                end
            endcase
        end
    end

    // State and timeout timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_RDY;
            timer <= 2'd0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wr_ptr0[AW-1:0]] <= req0_cmd;
        end
        if (push1) begin
            mem1[wr_ptr1[AW-1:0]] <= req1_cmd;
        end
    end

    // FIFO pointers; reset empties both queues at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr0 <= '0;
            rd_ptr0 <= '0;
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
        end else begin
            if (push0) begin
                wr_ptr0 <= wr_ptr0 + PTR_ONE;
            end
            if (push1) begin
                wr_ptr1 <= wr_ptr1 + PTR_ONE;
            end
            if (issue && !sel) begin
                rd_ptr0 <= rd_ptr0 + PTR_ONE;
            end
            if (issue && sel) begin
                rd_ptr1 <= rd_ptr1 + PTR_ONE;
            end
        end
    end

    // Registered controller interface, grant tracking, counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_cmd       <= 4'd0;
            lcd_cmd_valid <= 1'b0;
            grant_id      <= 1'b0;
            prio          <= 1'b0;
            issue_cnt     <= 8'd0;
            err           <= 1'b0;
            finished      <= 1'b0;
        end else begin
            lcd_cmd_valid <= issue;
            if (issue) begin
                lcd_cmd   <= pop_cmd;
                grant_id  <= sel;
                prio      <= !sel;
                issue_cnt <= issue_cnt + 8'd1;
            end
            if (bad0 || bad1 || timeout) begin
                err <= 1'b1;
            end
            if (lcd_done) begin
                finished <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb_lcd_cmd_sched: directed scenarios plus a randomized run, each cycle checked
// against a queue-based model of the scheduler's rules.
module tb_lcd_cmd_sched;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req0_cmd = 4'd0, req1_cmd = 4'd0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic       lcd_busy = 1'b0, lcd_done = 1'b0;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid, grant_id, err, finished;
    logic [7:0] issue_cnt;

    always #5 clk = ~clk;

    lcd_cmd_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .grant_id(grant_id),
        .issue_cnt(issue_cnt), .err(err), .finished(finished)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    localparam int PH_READY = 0, PH_STROBE = 1, PH_AWAIT = 2, PH_HELD = 3, PH_DONE = 4;
    int         q0[$];
    int         q1[$];
    int         m_phase = PH_READY;
    int         m_quiet = 0;
    int         m_turn = 0;
    logic [3:0] m_cmd = 4'd0;
    logic       m_valid = 1'b0, m_gid = 1'b0, m_err = 1'b0, m_fin = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    function automatic void model_clear();
        q0.delete();
        q1.delete();
        m_phase = PH_READY;
        m_quiet = 0;
        m_turn  = 0;
        m_cmd   = 4'd0;
        m_valid = 1'b0;
        m_gid   = 1'b0;
        m_err   = 1'b0;
        m_fin   = 1'b0;
        m_cnt   = 8'd0;
    endfunction

    // One clock edge of the scheduler's rules, using the inputs held before the edge.
    function automatic void model_step();
        bit r0, r1;
        int src;
        r0 = (q0.size() < DEPTH) && !m_fin;
        r1 = (q1.size() < DEPTH) && !m_fin;
        m_valid = 1'b0;
        if (lcd_done) begin
            m_fin   = 1'b1;
            m_phase = PH_DONE;
        end else if (m_phase == PH_READY) begin
            if (!lcd_busy && (q0.size() != 0 || q1.size() != 0)) begin
                if (q0.size() != 0 && q1.size() != 0) src = m_turn;
                else src = (q0.size() != 0) ? 0 : 1;
                m_cmd   = 4'((src == 1) ? q1.pop_front() : q0.pop_front());
                m_valid = 1'b1;
                m_gid   = src[0];
                m_cnt   = m_cnt + 8'd1;
                m_turn  = 1 - src;
                m_phase = PH_STROBE;
            end
        end else if (m_phase == PH_STROBE) begin
            m_phase = PH_AWAIT;
            m_quiet = 0;
        end else if (m_phase == PH_AWAIT) begin
            if (lcd_busy) m_phase = PH_HELD;
            else begin
                m_quiet++;
                if (m_quiet == 3) begin
                    m_err   = 1'b1;
                    m_phase = PH_READY;
                end
            end
        end else if (m_phase == PH_HELD) begin
            if (!lcd_busy) m_phase = PH_READY;
        end
        if (req0_valid && r0) begin
            if (req0_cmd < 4'd12) q0.push_back(int'(req0_cmd));
            else m_err = 1'b1;
        end
        if (req1_valid && r1) begin
            if (req1_cmd < 4'd12) q1.push_back(int'(req1_cmd));
            else m_err = 1'b1;
        end
    endfunction

    function automatic void compare_all();
        check("lcd_cmd", int'(lcd_cmd), int'(m_cmd));
        check("lcd_cmd_valid", int'(lcd_cmd_valid), int'(m_valid));
        check("grant_id", int'(grant_id), int'(m_gid));
        check("issue_cnt", int'(issue_cnt), int'(m_cnt));
        check("err", int'(err), int'(m_err));
        check("finished", int'(finished), int'(m_fin));
        check("req0_ready", int'(req0_ready), int'((q0.size() < DEPTH) && !m_fin));
        check("req1_ready", int'(req1_ready), int'((q1.size() < DEPTH) && !m_fin));
    endfunction

    // ---------------- stimulus helpers ----------------
    bit auto_busy = 1'b0;
    int resp_len = 0;
    int busy_left = 0;
    int cap_cmd[$];
    int cap_gid[$];

    // Advance one clock: step the model at the edge, compare on the falling edge,
    // record strobes and let the controller responder react.
    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else model_step();
        @(negedge clk);
        compare_all();
        if (lcd_cmd_valid) begin
            cap_cmd.push_back(int'(lcd_cmd));
            cap_gid.push_back(int'(grant_id));
            if (resp_len > 0) busy_left = resp_len + 1;
        end
        if (auto_busy) begin
            lcd_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_clear();
        busy_left = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input int r, input int cmd);
        bit ok;
        bit rdy;
        ok = 1'b0;
        if (r == 0) begin req0_cmd = 4'(cmd); req0_valid = 1'b1; end
        else begin req1_cmd = 4'(cmd); req1_valid = 1'b1; end
        for (int i = 0; i < 200 && !ok; i++) begin
            rdy = (r == 0) ? req0_ready : req1_ready;
            tick();
            ok = rdy;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("send_accepted", int'(ok), 1);
    endtask

    task automatic wait_caps(input int n, input int budget);
        for (int i = 0; i < budget && cap_cmd.size() < n; i++) tick();
        check("strobe_count", cap_cmd.size(), n);
    endtask

    task automatic clear_caps();
        cap_cmd.delete();
        cap_gid.delete();
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[4];
        int exp_g[4];
        int fin_age;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        // reset values, and ready on the first clock after deassertion
        check("rst_lcd_cmd", int'(lcd_cmd), 0);
        check("rst_valid", int'(lcd_cmd_valid), 0);
        check("rst_cnt", int'(issue_cnt), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready0", int'(req0_ready), 1);
        check("rst_ready1", int'(req1_ready), 1);

        // single issue and latency
        auto_busy = 1'b1; resp_len = 2; clear_caps();
        req0_cmd = 4'd1; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("lat_edge_n_valid", int'(lcd_cmd_valid), 0);
        tick();
        check("single_valid", int'(lcd_cmd_valid), 1);
        check("single_cmd", int'(lcd_cmd), 1);
        check("single_gid", int'(grant_id), 0);
        check("single_cnt", int'(issue_cnt), 1);
        tick();
        check("single_valid_drop", int'(lcd_cmd_valid), 0);
        repeat (8) tick();

        // fairness
        do_reset();
        auto_busy = 1'b0; lcd_busy = 1'b1;
        send(0, 5); send(0, 6); send(1, 7); send(1, 8);
        clear_caps();
        auto_busy = 1'b1; resp_len = 1;
        wait_caps(4, 100);
        exp_a = '{5, 7, 6, 8};
        exp_g = '{0, 1, 0, 1};
        for (int i = 0; i < 4 && i < cap_cmd.size(); i++) begin
            check("fair_cmd", cap_cmd[i], exp_a[i]);
            check("fair_gid", cap_gid[i], exp_g[i]);
        end

        // backpressure
        do_reset();
        auto_busy = 1'b0; lcd_busy = 1'b1;
        send(1, 2); send(1, 3); send(1, 4); send(1, 9);
        check("bp_ready1_full", int'(req1_ready), 0);
        check("bp_ready0", int'(req0_ready), 1);
        clear_caps();
        auto_busy = 1'b1; resp_len = 1;
        wait_caps(1, 20);
        check("bp_ready1_after_pop", int'(req1_ready), 1);
        wait_caps(4, 100);
        exp_a = '{2, 3, 4, 9};
        for (int i = 0; i < 4 && i < cap_cmd.size(); i++) begin
            check("bp_cmd", cap_cmd[i], exp_a[i]);
            check("bp_gid", cap_gid[i], 1);
        end

        // illegal code
        do_reset();
        auto_busy = 1'b1; resp_len = 1; clear_caps();
        send(0, 13);
        repeat (4) tick();
        check("illegal_err", int'(err), 1);
        check("illegal_cnt", int'(issue_cnt), 0);
        check("illegal_no_strobe", cap_cmd.size(), 0);

        // busy timeout
        do_reset();
        auto_busy = 1'b1; resp_len = 0; clear_caps();
        send(0, 3);
        wait_caps(1, 10);
        repeat (3) tick();
        check("to_err_early", int'(err), 0);
        tick();
        check("to_err_set", int'(err), 1);
        send(1, 6);
        wait_caps(2, 20);
        if (cap_cmd.size() >= 2) check("to_next_cmd", cap_cmd[1], 6);
        check("to_next_cnt", int'(issue_cnt), 2);

        // done
        do_reset();
        auto_busy = 1'b1; resp_len = 65; clear_caps();
        send(0, 0);
        wait_caps(1, 10);
        for (int i = 0; i < 200 && lcd_busy; i++) tick();
        check("done_busy_released", int'(lcd_busy), 0);
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        check("done_finished", int'(finished), 1);
        check("done_ready0", int'(req0_ready), 0);
        check("done_ready1", int'(req1_ready), 0);
        req0_cmd = 4'd2; req0_valid = 1'b1; req1_cmd = 4'd4; req1_valid = 1'b1;
        repeat (6) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("done_no_strobe", cap_cmd.size(), 1);
        check("done_cnt", int'(issue_cnt), 1);

        // reset in the middle of a long busy with commands queued
        do_reset();
        auto_busy = 1'b1; resp_len = 20; clear_caps();
        send(0, 1);
        wait_caps(1, 10);
        send(0, 2); send(1, 3);
        repeat (3) tick();
        #2 reset = 1'b1;
        model_clear();
        busy_left = 0;
        #1;
        check("midrst_valid", int'(lcd_cmd_valid), 0);
        check("midrst_cmd", int'(lcd_cmd), 0);
        check("midrst_cnt", int'(issue_cnt), 0);
        check("midrst_gid", int'(grant_id), 0);
        tick();
        tick();
        reset = 1'b0;
        clear_caps();
        repeat (10) tick();
        check("midrst_no_strobe", cap_cmd.size(), 0);
        check("midrst_cnt_after", int'(issue_cnt), 0);

        // issue counter wrap
        do_reset();
        auto_busy = 1'b1; resp_len = 1; clear_caps();
        for (int i = 0; i < 260; i++) send(0, i % 12);
        wait_caps(260, 400);
        check("wrap_cnt", int'(issue_cnt), 4);

        // randomized traffic
        do_reset();
        auto_busy = 1'b1;
        fin_age = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) resp_len = $urandom_range(0, 6);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_cmd = ($urandom_range(0, 19) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
            req1_cmd = ($urandom_range(0, 19) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
            lcd_done = ($urandom_range(0, 799) == 0);
            if (m_fin) fin_age++;
            if ($urandom_range(0, 499) == 0 || fin_age > 20) begin
                lcd_done = 1'b0;
                fin_age = 0;
                do_reset();
            end else begin
                tick();
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; lcd_done = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sched.md
LCD_CMD_SCHED -- requirements
Module: lcd_cmd_sched

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, the per-requester command FIFO depth (power of two, 2..16).
REQ-002 Port: clk, input, 1, clock, rising edge.
REQ-003 Port: reset, input, 1, reset, asynchronous, active-high.
REQ-004 Port: req0_cmd, input, 4, requester 0 command code.
REQ-005 Port: req0_valid, input, 1, requester 0 command present.
REQ-006 Port: req0_ready, output, 1, requester 0 FIFO can accept.
REQ-007 Port: req1_cmd, input, 4, requester 1 command code.
REQ-008 Port: req1_valid, input, 1, requester 1 command present.
REQ-009 Port: req1_ready, output, 1, requester 1 FIFO can accept.
REQ-010 Port: lcd_busy, input, 1, busy from the image controller.
REQ-011 Port: lcd_done, input, 1, done from the image controller.
REQ-012 Port: lcd_cmd, output, 4, registered command to the image controller.
REQ-013 Port: lcd_cmd_valid, output, 1, registered command strobe.
REQ-014 Port: grant_id, output, 1, source of the last issued command.
REQ-015 Port: issue_cnt, output, 8, count of issued commands, wraps 255->0.
REQ-016 Port: err, output, 1, sticky error flag.
REQ-017 Port: finished, output, 1, sticky flag set once lcd_done is seen.

Function
REQ-018 Enqueue: reqN_valid&&reqN_ready at a rising edge writes reqN_cmd to FIFO N.
REQ-019 reqN_ready = !fullN && !finished.
REQ-020 Codes 12..15 are accepted by the handshake but are not stored, and they set err.
REQ-021 FSM states: WAIT_RDY, ISSUE, WAIT_BUSY, WAIT_IDLE, FINISHED.
REQ-022 WAIT_RDY: if lcd_busy==0 and any FIFO is non-empty, the block pops the granted FIFO, loads lcd_cmd, sets lcd_cmd_valid=1, updates grant_id, increments issue_cnt, and moves to ISSUE.
REQ-023 ISSUE: lcd_cmd_valid is high for exactly one cycle; the next edge clears it and moves to WAIT_BUSY with timer=0.
REQ-024 WAIT_BUSY: lcd_busy==1 moves to WAIT_IDLE; otherwise the timer increments, and at timer==3 the block sets err and returns to WAIT_RDY.
REQ-025 WAIT_IDLE: lcd_busy==0 moves to WAIT_RDY; there is no timeout, because a write (cmd 0) holds busy for 64+ cycles.
REQ-026 Arbitration is round-robin. With both FIFOs non-empty, the grant goes to the FIFO not granted last. With one FIFO non-empty, the grant goes to that FIFO. The grant pointer updates only on issue.
REQ-027 Issue latency: a command enqueued at edge N into an empty system with lcd_busy=0 drives lcd_cmd_valid=1 after edge N+1 (FIFO registered, no bypass).
REQ-028 Simultaneous enqueue and pop on the same FIFO is legal when full: the pop frees the slot, but ready is computed from pre-edge full, so that enqueue is refused.
REQ-029 Pointers wrap modulo FIFO_DEPTH, and the full/empty distinction uses an extra pointer bit.
REQ-030 lcd_done==1 in any state moves to FINISHED at the next edge and sets finished. FINISHED is absorbing until reset, holds lcd_cmd_valid=0, and both ready outputs are 0.
REQ-031 lcd_cmd holds its last value when lcd_cmd_valid=0.

Reset
REQ-032 Asynchronous reset sets FSM=WAIT_RDY, empties both FIFOs, sets the grant pointer to favour requester 0, and sets lcd_cmd=0, lcd_cmd_valid=0, grant_id=0, issue_cnt=0, err=0, finished=0.
REQ-033 Reset mid-operation, including during ISSUE or WAIT_IDLE, discards queued commands immediately with no further strobe.
REQ-034 After reset deassertion, req0_ready=req1_ready=1 on the first clock.

Verification
REQ-035 Single issue: req0 sends cmd 1 (shift up), lcd_busy=0. Required response: lcd_cmd=1 with a one-cycle strobe 2 edges later, grant_id=0, issue_cnt=1.
REQ-036 Fairness: preload req0={5,6} and req1={7,8}, then model busy 1 cycle per command. Required issue order: 5,7,6,8, with grant_id 0,1,0,1.
REQ-037 Backpressure: 4 cmds to req1 with lcd_busy held at 1 give req1_ready=0 after the 4th. Releasing busy issues all 4 in order, and ready returns after the first pop.
REQ-038 Illegal code and timeout: req0 cmd 13 gives err=1 with nothing issued. After reset, issuing a cmd with lcd_busy stuck at 0 gives err=1 three cycles after the strobe, and the next command still issues.
REQ-039 Done: issue cmd 0, model busy high for 65 cycles, then pulse lcd_done. Required response: finished=1, ready outputs=0, and further valid inputs are ignored with no strobe.
REQ-040 Reset mid-WAIT_IDLE with 2 queued commands: all outputs are at reset values, and no strobe occurs after deassertion without new input.
